// File: rtl/run_controller_pkg.sv
// Shared types and helpers for the start/ack run sequencer.
package run_controller_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        LOAD   = 3'd2,
        RUN    = 3'd3,
        FINISH = 3'd4
    } run_state_t;

    // Instruction word substituted into the core whenever it is not running.
    localparam logic [8:0] NOP_INSTR = 9'b100000000;

    // Width of the program select field; at least one bit even for a single program.
    function automatic int sel_w(input int num_progs);
        return (num_progs <= 1) ? 1 : $clog2(num_progs);
    endfunction

endpackage

// File: rtl/run_controller_if.sv
// Handshake bundle between the testbench/top level (master) and the run sequencer (slave).
interface run_controller_if #(
    parameter int SEL_W = 2,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic             start;
    logic [SEL_W-1:0] prog_sel;
    logic             done_i;
    logic             run_o;
    logic             pc_load;
    logic [PC_W-1:0]  pc_load_val;
    logic             ack;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output start, prog_sel, done_i,
        input  run_o, pc_load, pc_load_val, ack, timeout, cycle_count
    );

    modport slave (
        input  start, prog_sel, done_i,
        output run_o, pc_load, pc_load_val, ack, timeout, cycle_count
    );
endinterface

// File: rtl/run_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over enable.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);
    // Count up while enabled, sticking at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + 1'b1;
        end
    end
endmodule

// File: rtl/run_controller.sv
// Run sequencer: arms on start, launches on start's falling edge at a selected
// entry PC, gates the core while idle, counts run cycles and finishes on done or timeout.
module run_controller
    import run_controller_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 4096,
    parameter int NUM_PROGS = 4,
    parameter int PC_W      = 32,
    parameter logic [NUM_PROGS-1:0][PC_W-1:0] ENTRY_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    run_controller_if.slave bus
);
    localparam int SEL_W = sel_w(NUM_PROGS);
    localparam bit TO_EN = (TIMEOUT != 0);
    // Count value seen in the last permitted RUN cycle before a forced finish.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    if (longint'(TIMEOUT) > (longint'(1) << CNT_W)) begin : g_cnt_too_small
        $error("run_controller: CNT_W=%0d cannot reach TIMEOUT=%0d", CNT_W, TIMEOUT);
    end

    run_state_t       state;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_clamped;
    logic             cnt_clr;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;
    logic             pc_load_q;
    logic             ack_q;
    logic             timeout_q;

    // Out-of-range program indices fall back to entry point 0.
    always_comb begin
        sel_clamped = bus.prog_sel;
        if (int'(bus.prog_sel) >= NUM_PROGS) begin
            sel_clamped = '0;
        end
    end

    // Counter restarts whenever the sequencer arms, and runs only in RUN.
    assign cnt_clr = ((state == IDLE) || (state == FINISH)) && bus.start;
    assign cnt_en  = (state == RUN);

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .q     (cnt_q)
    );

    // Sequencer FSM with registered Moore outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sel_q     <= '0;
            run_q     <= 1'b0;
            pc_load_q <= 1'b0;
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            pc_load_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= ARMED;
                        sel_q <= sel_clamped;
                    end
                end
                ARMED: begin
                    if (!bus.start) begin
                        state     <= LOAD;
                        pc_load_q <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= RUN;
                    run_q <= 1'b1;
                end
                RUN: begin
                    // done takes precedence over a coincident timeout
                    if (bus.done_i) begin
                        state     <= FINISH;
                        run_q     <= 1'b0;
                        ack_q     <= 1'b1;
                        timeout_q <= 1'b0;
                    end else if (TO_EN && (cnt_q == TO_LAST)) begin
                        state     <= FINISH;
                        run_q     <= 1'b0;
                        ack_q     <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
                FINISH: begin
                    if (bus.start) begin
                        state     <= ARMED;
                        sel_q     <= sel_clamped;
                        ack_q     <= 1'b0;
                        timeout_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    run_q     <= 1'b0;
                    ack_q     <= 1'b0;
                    timeout_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.run_o       = run_q;
    assign bus.pc_load     = pc_load_q;
    assign bus.pc_load_val = ENTRY_PC[sel_q];
    assign bus.ack         = ack_q;
    assign bus.timeout     = timeout_q;
    assign bus.cycle_count = cnt_q;
endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: a long-timeout instance (a) and a TIMEOUT=8 instance (b).
module tb_run_controller;
    import run_controller_pkg::*;

    localparam int CNT_W     = 16;
    localparam int NUM_PROGS = 4;
    localparam int PC_W      = 32;
    localparam int SEL_W     = sel_w(NUM_PROGS);
    localparam logic [NUM_PROGS-1:0][PC_W-1:0] ENTRIES = {32'd112, 32'd40, 32'd24, 32'd8};

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    run_controller_if #(.SEL_W(SEL_W), .PC_W(PC_W), .CNT_W(CNT_W)) bus_a ();
    run_controller_if #(.SEL_W(SEL_W), .PC_W(PC_W), .CNT_W(CNT_W)) bus_b ();

    run_controller #(
        .CNT_W(CNT_W), .TIMEOUT(4096), .NUM_PROGS(NUM_PROGS), .PC_W(PC_W), .ENTRY_PC(ENTRIES)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    run_controller #(
        .CNT_W(CNT_W), .TIMEOUT(8), .NUM_PROGS(NUM_PROGS), .PC_W(PC_W), .ENTRY_PC(ENTRIES)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        int loads;
        reset = 1'b1;
        bus_a.start = 1'b0; bus_a.prog_sel = '0; bus_a.done_i = 1'b0;
        bus_b.start = 1'b0; bus_b.prog_sel = '0; bus_b.done_i = 1'b0;
        tick(2);
        reset = 1'b0;
        loads = 0;
        for (int i = 0; i < 50; i++) begin
            // a stray done while idle must be ignored
            bus_a.done_i = (i == 20);
            tick();
            if (bus_a.pc_load === 1'b1) loads++;
        end
        bus_a.done_i = 1'b0;
        checks++; if (loads !== 0) begin errors++; $display("FAIL reset_pc_load got %0d pulses exp 0", loads); end
        checks++; if (bus_a.run_o !== 1'b0) begin errors++; $display("FAIL reset_run_o got %b exp 0", bus_a.run_o); end
        checks++; if (bus_a.ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", bus_a.ack); end
        checks++; if (bus_a.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", bus_a.timeout); end
        checks++; if (bus_a.cycle_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus_a.cycle_count); end
        checks++; if (bus_a.pc_load_val !== 32'd8) begin errors++; $display("FAIL reset_pc_val got %0d exp 8", bus_a.pc_load_val); end
        checks++; if (bus_b.ack !== 1'b0) begin errors++; $display("FAIL reset_ack_b got %b exp 0", bus_b.ack); end
    endtask

    task automatic test_done_run;
        bus_a.prog_sel = 2'd2;
        bus_a.start = 1'b1;
        tick(3);
        checks++; if (bus_a.run_o !== 1'b0) begin errors++; $display("FAIL armed_run_o got %b exp 0", bus_a.run_o); end
        checks++; if (bus_a.pc_load !== 1'b0) begin errors++; $display("FAIL armed_pc_load got %b exp 0", bus_a.pc_load); end
        bus_a.start = 1'b0;
        tick();
        checks++; if (bus_a.pc_load !== 1'b1) begin errors++; $display("FAIL load_strobe got %b exp 1", bus_a.pc_load); end
        checks++; if (bus_a.pc_load_val !== 32'd40) begin errors++; $display("FAIL load_val got %0d exp 40", bus_a.pc_load_val); end
        checks++; if (bus_a.run_o !== 1'b0) begin errors++; $display("FAIL load_run_o got %b exp 0", bus_a.run_o); end
        tick();
        checks++; if (bus_a.run_o !== 1'b1) begin errors++; $display("FAIL run_run_o got %b exp 1", bus_a.run_o); end
        checks++; if (bus_a.pc_load !== 1'b0) begin errors++; $display("FAIL run_pc_load got %b exp 0", bus_a.pc_load); end
        // a start request during RUN is ignored
        bus_a.start = 1'b1;
        tick(9);
        bus_a.start = 1'b0;
        checks++; if (bus_a.cycle_count !== 16'd9) begin errors++; $display("FAIL run_count got %0d exp 9", bus_a.cycle_count); end
        checks++; if (bus_a.run_o !== 1'b1) begin errors++; $display("FAIL run_still got %b exp 1", bus_a.run_o); end
        bus_a.done_i = 1'b1;
        tick();
        bus_a.done_i = 1'b0;
        checks++; if (bus_a.ack !== 1'b1) begin errors++; $display("FAIL done_ack got %b exp 1", bus_a.ack); end
        checks++; if (bus_a.timeout !== 1'b0) begin errors++; $display("FAIL done_timeout got %b exp 0", bus_a.timeout); end
        checks++; if (bus_a.cycle_count !== 16'd10) begin errors++; $display("FAIL done_count got %0d exp 10", bus_a.cycle_count); end
        checks++; if (bus_a.run_o !== 1'b0) begin errors++; $display("FAIL done_run_o got %b exp 0", bus_a.run_o); end
        tick(4);
        checks++; if (bus_a.ack !== 1'b1) begin errors++; $display("FAIL hold_ack got %b exp 1", bus_a.ack); end
        checks++; if (bus_a.cycle_count !== 16'd10) begin errors++; $display("FAIL hold_count got %0d exp 10", bus_a.cycle_count); end
    endtask

    task automatic test_restart;
        bus_a.prog_sel = 2'd1;
        bus_a.start = 1'b1;
        tick();
        checks++; if (bus_a.ack !== 1'b0) begin errors++; $display("FAIL restart_ack got %b exp 0", bus_a.ack); end
        checks++; if (bus_a.cycle_count !== 16'd0) begin errors++; $display("FAIL restart_count got %0d exp 0", bus_a.cycle_count); end
        checks++; if (bus_a.pc_load_val !== 32'd24) begin errors++; $display("FAIL restart_val got %0d exp 24", bus_a.pc_load_val); end
        bus_a.start = 1'b0;
        tick();
        checks++; if (bus_a.pc_load !== 1'b1) begin errors++; $display("FAIL restart_load got %b exp 1", bus_a.pc_load); end
        tick(3);
        bus_a.done_i = 1'b1;
        tick();
        bus_a.done_i = 1'b0;
        checks++; if (bus_a.ack !== 1'b1) begin errors++; $display("FAIL restart_done_ack got %b exp 1", bus_a.ack); end
        checks++; if (bus_a.cycle_count !== 16'd3) begin errors++; $display("FAIL restart_done_count got %0d exp 3", bus_a.cycle_count); end
    endtask

    task automatic test_timeout;
        bus_b.prog_sel = 2'd3;
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        tick(2);
        checks++; if (bus_b.run_o !== 1'b1) begin errors++; $display("FAIL to_run_o got %b exp 1", bus_b.run_o); end
        tick(7);
        checks++; if (bus_b.ack !== 1'b0) begin errors++; $display("FAIL to_early_ack got %b exp 0", bus_b.ack); end
        checks++; if (bus_b.cycle_count !== 16'd7) begin errors++; $display("FAIL to_early_count got %0d exp 7", bus_b.cycle_count); end
        tick();
        checks++; if (bus_b.ack !== 1'b1) begin errors++; $display("FAIL to_ack got %b exp 1", bus_b.ack); end
        checks++; if (bus_b.timeout !== 1'b1) begin errors++; $display("FAIL to_flag got %b exp 1", bus_b.timeout); end
        checks++; if (bus_b.cycle_count !== 16'd8) begin errors++; $display("FAIL to_count got %0d exp 8", bus_b.cycle_count); end
        tick(5);
        checks++; if (bus_b.timeout !== 1'b1) begin errors++; $display("FAIL to_hold got %b exp 1", bus_b.timeout); end
        checks++; if (bus_b.cycle_count !== 16'd8) begin errors++; $display("FAIL to_hold_count got %0d exp 8", bus_b.cycle_count); end
    endtask

    task automatic test_done_vs_timeout;
        bus_b.prog_sel = 2'd0;
        bus_b.start = 1'b1;
        tick();
        checks++; if (bus_b.timeout !== 1'b0) begin errors++; $display("FAIL dvt_rearm_flag got %b exp 0", bus_b.timeout); end
        bus_b.start = 1'b0;
        tick(2);
        tick(7);
        bus_b.done_i = 1'b1;
        tick();
        bus_b.done_i = 1'b0;
        checks++; if (bus_b.ack !== 1'b1) begin errors++; $display("FAIL dvt_ack got %b exp 1", bus_b.ack); end
        checks++; if (bus_b.timeout !== 1'b0) begin errors++; $display("FAIL dvt_flag got %b exp 0", bus_b.timeout); end
        checks++; if (bus_b.cycle_count !== 16'd8) begin errors++; $display("FAIL dvt_count got %0d exp 8", bus_b.cycle_count); end
    endtask

    task automatic test_reset_in_run;
        bus_a.prog_sel = 2'd3;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        tick(2);
        tick(5);
        checks++; if (bus_a.cycle_count !== 16'd5) begin errors++; $display("FAIL rr_pre_count got %0d exp 5", bus_a.cycle_count); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus_a.run_o !== 1'b0) begin errors++; $display("FAIL rr_run_o got %b exp 0", bus_a.run_o); end
        checks++; if (bus_a.cycle_count !== 16'd0) begin errors++; $display("FAIL rr_count got %0d exp 0", bus_a.cycle_count); end
        checks++; if (bus_a.pc_load_val !== 32'd8) begin errors++; $display("FAIL rr_val got %0d exp 8", bus_a.pc_load_val); end
        checks++; if (bus_a.ack !== 1'b0) begin errors++; $display("FAIL rr_ack got %b exp 0", bus_a.ack); end
        checks++; if (bus_b.ack !== 1'b0) begin errors++; $display("FAIL rr_ack_b got %b exp 0", bus_b.ack); end
        tick();
        checks++; if (bus_a.ack !== 1'b0) begin errors++; $display("FAIL rr_no_ack got %b exp 0", bus_a.ack); end
        reset = 1'b0;
        bus_a.prog_sel = 2'd2;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        tick();
        checks++; if (bus_a.pc_load_val !== 32'd40) begin errors++; $display("FAIL rr_new_val got %0d exp 40", bus_a.pc_load_val); end
        tick();
        bus_a.done_i = 1'b1;
        tick();
        bus_a.done_i = 1'b0;
        checks++; if (bus_a.ack !== 1'b1) begin errors++; $display("FAIL rr_new_ack got %b exp 1", bus_a.ack); end
        checks++; if (bus_a.cycle_count !== 16'd1) begin errors++; $display("FAIL rr_new_count got %0d exp 1", bus_a.cycle_count); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_done_run();
        test_restart();
        test_timeout();
        test_done_vs_timeout();
        test_reset_in_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
